// File: rtl/matrix_alu_pkg.sv
// Shared types and constants for the 2x2 matrix ALU: opcodes, FSM states,
// per-opcode EXEC lengths and the result-width helper.
package matrix_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_TRANS = 3'd3,
    OP_DET   = 3'd4,
    OP_ADJ   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned EXEC_LEN_SINGLE = 1;
  localparam int unsigned EXEC_LEN_MUL    = 4;
  localparam int unsigned EXEC_LEN_ADJ    = 2;

  function automatic int rw_of(input int w);
    return 2 * w + 2;
  endfunction

  // Index of the final EXEC cycle for an opcode (cycle counter starts at 0).
  function automatic logic [1:0] exec_last(input logic [2:0] op);
    case (op)
      OP_MUL:  exec_last = 2'(EXEC_LEN_MUL - 1);
      OP_ADJ:  exec_last = 2'(EXEC_LEN_ADJ - 1);
      default: exec_last = 2'(EXEC_LEN_SINGLE - 1);
    endcase
  endfunction

endpackage

// File: rtl/matrix_alu_2x2_seq_if.sv
// Request/result channel bundle for matrix_alu_2x2_seq; the master side
// issues requests and consumes results, the slave side is the engine.
interface matrix_alu_if #(parameter int W = 4);
  import matrix_alu_pkg::*;

  localparam int RW = rw_of(W);

  // Both channels are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid stays asserted with stable payload
  // until that edge, and ready may depend on nothing but the receiver's state.
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [4*W-1:0]    a;
  logic [4*W-1:0]    b;
  logic              out_valid;
  logic              out_ready;
  logic [4*RW-1:0]   c;
  logic              det_zero;
  logic              op_err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, c, det_zero, op_err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, c, det_zero, op_err
  );

endinterface

// File: rtl/matrix_mac_unit.sv
// Combinational dual-product unit: x1*y1 +/- x2*y2 on zero-extended
// unsigned operands, producing a two's-complement RW-bit result.
module matrix_mac_unit
  import matrix_alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]         x1,
  input  logic [W-1:0]         y1,
  input  logic [W-1:0]         x2,
  input  logic [W-1:0]         y2,
  input  logic                 sub,
  output logic [rw_of(W)-1:0]  p
);

  localparam int RW = rw_of(W);

  logic [RW-1:0] p1;
  logic [RW-1:0] p2;

  // Each product is below 2**(2W), so the sum or difference fits in 2W+2 bits.
  assign p1 = {{(RW-W){1'b0}}, x1} * {{(RW-W){1'b0}}, y1};
  assign p2 = {{(RW-W){1'b0}}, x2} * {{(RW-W){1'b0}}, y2};
  assign p  = sub ? (p1 - p2) : (p1 + p2);

endmodule

// File: rtl/matrix_alu_2x2_seq.sv
// Sequential 2x2 matrix ALU: ADD/SUB/MUL/TRANS/DET (and ADJ when the
// MATRIX_ALU_ADJ_EN macro is defined) on one shared MAC, valid/ready in and out.
module matrix_alu_2x2_seq
  import matrix_alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        rst,
  matrix_alu_if.slave bus,
  output state_e      dbg_state_o
);

  localparam int RW = rw_of(W);

  typedef logic [0:3][W-1:0]  elems_t;
  typedef logic [0:3][RW-1:0] res_t;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  elems_t        a_q, a_d;
  elems_t        b_q, b_d;
  res_t          c_q, c_d;
  logic          dz_q, dz_d;
  logic          err_q, err_d;

  logic [W-1:0]  mac_x1, mac_y1, mac_x2, mac_y2;
  logic          mac_sub;
  logic [RW-1:0] mac_p;
  logic          op_legal;
  logic [1:0]    last_cnt;

  function automatic logic [RW-1:0] zext(input logic [W-1:0] v);
    return {{(RW-W){1'b0}}, v};
  endfunction

  always_comb begin
    op_legal = (op_q <= OP_DET);
`ifdef MATRIX_ALU_ADJ_EN
    if (op_q == OP_ADJ) op_legal = 1'b1;
`endif
    last_cnt = op_legal ? exec_last(op_q) : 2'd0;
  end

  // MUL walks c11,c12,c21,c22 with cnt = {row, col}; DET/ADJ reuse the MAC
  // as a11*a22 - a12*a21.
  always_comb begin
    mac_x1  = a_q[0];
    mac_y1  = a_q[3];
    mac_x2  = a_q[1];
    mac_y2  = a_q[2];
    mac_sub = 1'b1;
    if (op_q == OP_MUL) begin
      mac_x1  = a_q[{cnt_q[1], 1'b0}];
      mac_y1  = b_q[{1'b0, cnt_q[0]}];
      mac_x2  = a_q[{cnt_q[1], 1'b1}];
      mac_y2  = b_q[{1'b1, cnt_q[0]}];
      mac_sub = 1'b0;
    end
  end

  matrix_mac_unit #(.W(W)) u_mac (
    .x1  (mac_x1),
    .y1  (mac_y1),
    .x2  (mac_x2),
    .y2  (mac_y2),
    .sub (mac_sub),
    .p   (mac_p)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    dz_d    = dz_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_EXEC;
          cnt_d   = 2'd0;
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = '0;
          dz_d    = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD: for (int i = 0; i < 4; i++) c_d[i] = zext(a_q[i]) + zext(b_q[i]);
          OP_SUB: for (int i = 0; i < 4; i++) c_d[i] = zext(a_q[i]) - zext(b_q[i]);
          OP_TRANS: c_d = {zext(a_q[0]), zext(a_q[2]), zext(a_q[1]), zext(a_q[3])};
          OP_MUL: c_d[cnt_q] = mac_p;
          OP_DET: begin
            c_d[0] = mac_p;
            dz_d   = (mac_p == '0);
          end
`ifdef MATRIX_ALU_ADJ_EN
          OP_ADJ: begin
            // Cycle 0 latches det==0; cycle 1 writes the adjugate only for a
            // nonsingular matrix, leaving the accept-time zeros otherwise.
            if (cnt_q == 2'd0) begin
              dz_d = (mac_p == '0);
            end else if (!dz_q) begin
              c_d = {zext(a_q[3]), -zext(a_q[1]), -zext(a_q[2]), zext(a_q[0])};
            end
          end
`endif
          default: err_d = 1'b1;
        endcase

        if (cnt_q == last_cnt) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.c         = c_q;
  assign bus.det_zero  = dz_q;
  assign bus.op_err    = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_matrix_alu_2x2_seq.sv
// Directed and randomized bench for matrix_alu_2x2_seq (W=4) against an
// arithmetic reference model; ADJ expectations follow MATRIX_ALU_ADJ_EN.
module tb_matrix_alu_2x2_seq;
  import matrix_alu_pkg::*;

  localparam int W  = 4;
  localparam int RW = 10;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;
  int     cyc = 0;

  int          tests = 0;
  int          fails = 0;
  logic [39:0] exp_q[$];
  logic [39:0] last_c;
  logic        last_dz, last_err;
  bit          adj_en;

  matrix_alu_if #(.W(W)) bus ();

  matrix_alu_2x2_seq #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer matrix arithmetic, truncated to RW bits.
  function automatic void model(input logic [2:0] op, input logic [15:0] a_p, input logic [15:0] b_p,
                                output logic [39:0] e_c, output logic e_dz, output logic e_err,
                                output int e_n);
    int a[4];
    int b[4];
    int e[4];
    int det;
    for (int i = 0; i < 4; i++) begin
      a[i] = int'(a_p[15-4*i -: 4]);
      b[i] = int'(b_p[15-4*i -: 4]);
      e[i] = 0;
    end
    e_dz = 1'b0;
    e_err = 1'b0;
    e_n = 1;
    det = a[0] * a[3] - a[1] * a[2];
    case (op)
      3'd0: for (int i = 0; i < 4; i++) e[i] = a[i] + b[i];
      3'd1: for (int i = 0; i < 4; i++) e[i] = a[i] - b[i];
      3'd2: begin
        e[0] = a[0] * b[0] + a[1] * b[2];
        e[1] = a[0] * b[1] + a[1] * b[3];
        e[2] = a[2] * b[0] + a[3] * b[2];
        e[3] = a[2] * b[1] + a[3] * b[3];
        e_n = 4;
      end
      3'd3: begin
        e[0] = a[0]; e[1] = a[2]; e[2] = a[1]; e[3] = a[3];
      end
      3'd4: begin
        e[0] = det;
        e_dz = (det == 0);
      end
      3'd5: begin
        if (adj_en) begin
          e_n = 2;
          if (det == 0) begin
            e_dz = 1'b1;
          end else begin
            e[0] = a[3]; e[1] = -a[1]; e[2] = -a[2]; e[3] = a[0];
          end
        end else begin
          e_err = 1'b1;
        end
      end
      default: e_err = 1'b1;
    endcase
    e_c = {e[0][9:0], e[1][9:0], e[2][9:0], e[3][9:0]};
  endfunction

  // driver: one full transaction with optional result back-pressure
  task automatic do_txn(input string tag, input logic [2:0] op, input logic [15:0] a_p,
                        input logic [15:0] b_p, input int hold);
    logic [39:0] e_c;
    logic        e_dz, e_err;
    int          e_n, k;
    model(op, a_p, b_p, e_c, e_dz, e_err, e_n);
    exp_q.push_back(e_c);
    bus.op = op; bus.a = a_p; bus.b = b_p;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    k = 0;
    while (!bus.in_ready && k < 20) begin @(posedge clk); #1; k++; end
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
    k = 0;
    while (!bus.out_valid && k < 20) begin @(posedge clk); #1; k++; end
    check({tag, " latency"}, 64'(k), 64'(e_n));
    e_c = exp_q.pop_front();
    last_c = bus.c; last_dz = bus.det_zero; last_err = bus.op_err;
    check({tag, " c"}, 64'(bus.c), 64'(e_c));
    check({tag, " det_zero"}, 64'(bus.det_zero), 64'(e_dz));
    check({tag, " op_err"}, 64'(bus.op_err), 64'(e_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold c"}, 64'(bus.c), 64'(e_c));
      check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " release out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " release in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [39:0] e_c;
    logic        e_dz, e_err;
    int          e_n, k, prev_acc, seen;
    logic [2:0]  op;
    logic [15:0] ra, rb;

`ifdef MATRIX_ALU_ADJ_EN
    adj_en = 1'b1;
`else
    adj_en = 1'b0;
`endif

    // reset with in_valid asserted, which must be ignored
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.op = 3'd0; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b0;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset c", 64'(bus.c), 64'd0);
    check("reset det_zero", 64'(bus.det_zero), 64'd0);
    check("reset op_err", 64'(bus.op_err), 64'd0);
    check("reset state", 64'(dbg_state), 64'(S_IDLE));

    do_txn("add", 3'd0, {4'd15, 4'd1, 4'd2, 4'd3}, {4'd15, 4'd0, 4'd0, 4'd0}, 0);
    check("add literal", 64'(last_c), 64'({10'd30, 10'd1, 10'd2, 10'd3}));
    do_txn("sub", 3'd1, {4'd1, 4'd5, 4'd0, 4'd0}, {4'd3, 4'd2, 4'd0, 4'd0}, 0);
    check("sub literal", 64'(last_c), 64'({10'h3FE, 10'd3, 10'd0, 10'd0}));
    do_txn("mul", 3'd2, {4'd1, 4'd2, 4'd3, 4'd4}, {4'd5, 4'd6, 4'd7, 4'd8}, 3);
    check("mul literal", 64'(last_c), 64'({10'd19, 10'd22, 10'd43, 10'd50}));
    do_txn("trans", 3'd3, {4'd9, 4'd10, 4'd11, 4'd12}, 16'hFFFF, 1);
    check("trans literal", 64'(last_c), 64'({10'd9, 10'd11, 10'd10, 10'd12}));
    do_txn("det", 3'd4, {4'd3, 4'd8, 4'd4, 4'd6}, 16'h0000, 0);
    check("det literal", 64'(last_c), 64'({10'h3F2, 30'd0}));
    check("det literal dz", 64'(last_dz), 64'd0);
    do_txn("adj singular", 3'd5, {4'd2, 4'd4, 4'd1, 4'd2}, 16'h0000, 0);
    check("adj singular c", 64'(last_c), 64'd0);
    check("adj singular dz", 64'(last_dz), 64'(adj_en));
    check("adj singular err", 64'(last_err), 64'(!adj_en));
    do_txn("adj", 3'd5, {4'd3, 4'd1, 4'd2, 4'd1}, 16'h0000, 2);
    check("adj literal", 64'(last_c),
          adj_en ? 64'({10'd1, 10'h3FF, 10'h3FE, 10'd3}) : 64'd0);
    do_txn("illegal7", 3'd7, 16'h1234, 16'h5678, 0);
    check("illegal7 literal", 64'(last_c), 64'd0);
    check("illegal7 err", 64'(last_err), 64'd1);

    // reset in the second EXEC cycle of a MUL discards the transaction
    bus.op = 3'd2; bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    k = 0;
    while (!bus.in_ready && k < 20) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst mid-mul exec", 64'(dbg_state), 64'(S_EXEC));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid-mul in_ready", 64'(bus.in_ready), 64'd1);
    check("rst mid-mul c", 64'(bus.c), 64'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("rst mid-mul no result", 64'(seen), 64'd0);

    // back-to-back ADD/TRANS with out_ready tied high
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd3;
      ra = 16'($urandom); rb = 16'($urandom);
      model(op, ra, rb, e_c, e_dz, e_err, e_n);
      exp_q.push_back(e_c);
      bus.op = op; bus.a = ra; bus.b = rb;
      k = 0;
      while (!bus.in_ready && k < 20) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      if (i > 0) check("b2b accept spacing", 64'(cyc - prev_acc), 64'd3);
      prev_acc = cyc;
      k = 0;
      while (!bus.out_valid && k < 20) begin @(posedge clk); #1; k++; end
      e_c = exp_q.pop_front();
      check("b2b c", 64'(bus.c), 64'(e_c));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // randomized transactions across all opcodes
    for (int i = 0; i < 40; i++) begin
      do_txn("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
             $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
